// File: rtl/pipe_ctrl.sv
// Pipeline run/drain/halt controller with load-use stall, branch flush
// and saturating performance counters (cycle, stall, flush).
module pipe_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             clr_cnt,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_br_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [2:0] LAST = 3'(DRAIN_CYCLES - 1);

  state_t     cur, nxt;
  logic [2:0] drain_cnt, drain_nxt;
  logic       load_use;
  logic       ev_br, ev_hlt, ev_lu;
  logic       inc_cyc, inc_stall, inc_flush;

  assign state = cur;

  assign load_use = id_valid && ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) ||
                     (id_uses_rt && (ex_rd == id_rt)));

  // Mutually exclusive RUN events in priority order.
  assign ev_br  = mem_br_taken;
  assign ev_hlt = halt_req && !mem_br_taken;
  assign ev_lu  = load_use && !mem_br_taken && !halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= IDLE;
      drain_cnt <= 3'd0;
    end else begin
      cur       <= nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    nxt         = cur;
    drain_nxt   = drain_cnt;
    inc_cyc     = 1'b0;
    inc_stall   = 1'b0;
    inc_flush   = 1'b0;
    unique case (cur)
      IDLE, HALT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
        if (start) nxt = RUN;
      end
      RUN: begin
        inc_cyc = 1'b1;
        unique case (1'b1)
          ev_br: begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            inc_flush   = 1'b1;
            // Halt still honoured; PC takes the target first.
            if (halt_req) begin
              nxt       = DRAIN;
              drain_nxt = 3'd0;
            end
          end
          ev_hlt: begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            nxt        = DRAIN;
            drain_nxt  = 3'd0;
          end
          ev_lu: begin
            idex_bubble = 1'b1;
            inc_stall   = 1'b1;
          end
          default: begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        endcase
      end
      DRAIN: begin
        inc_cyc    = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b1;
        if (mem_br_taken) begin
          pc_we       = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
          inc_flush   = 1'b1;
        end
        drain_nxt = drain_cnt + 3'd1;
        if (drain_cnt == LAST) nxt = HALT;
      end
      default: nxt = IDLE;
    endcase
  end

  localparam logic [CNT_W-1:0] CMAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (inc_cyc && cycle_cnt != CMAX)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (inc_stall && stall_cnt != CMAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (inc_flush && flush_cnt != CMAX)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: behavioural model compared every
// cycle plus directed literal checks; a 3-bit-counter instance for saturation.
module tb_pipe_ctrl;

  localparam int DC   = 4;
  localparam int MAXC = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, halt_req, clr_cnt, id_valid, id_uses_rt;
  logic ex_memread, mem_br_taken;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0] state;
  logic [15:0] cycle_cnt, stall_cnt, flush_cnt;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .clr_cnt(clr_cnt), .id_valid(id_valid), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_br_taken(mem_br_taken), .pc_we(pc_we),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .state(state), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // Small-counter instance for saturation
  logic s_rst_n, s_start, s_clr;
  logic s_pc, s_ifwe, s_iff, s_idb, s_exf;
  logic [1:0] s_state;
  logic [2:0] s_cyc, s_stall, s_flush;

  pipe_ctrl #(.CNT_W(3)) sat (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .halt_req(1'b0),
    .clr_cnt(s_clr), .id_valid(1'b0), .id_rs(5'd0), .id_rt(5'd0),
    .id_uses_rt(1'b0), .ex_memread(1'b0), .ex_rd(5'd0),
    .mem_br_taken(1'b0), .pc_we(s_pc), .ifid_we(s_ifwe),
    .ifid_flush(s_iff), .idex_bubble(s_idb), .exmem_flush(s_exf),
    .state(s_state), .cycle_cnt(s_cyc), .stall_cnt(s_stall),
    .flush_cnt(s_flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode uses the externally visible state codes.
  int m_mode = 0, m_d = 0, m_cyc = 0, m_stall = 0, m_flush = 0;
  int n_mode = 0, n_d = 0, n_cyc = 0, n_stall = 0, n_flush = 0;

  function automatic int sat_inc(input int x);
    return (x < MAXC) ? x + 1 : x;
  endfunction

  always @(negedge rst_n) begin
    m_mode = 0; m_d = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    n_mode = 0; n_d = 0; n_cyc = 0; n_stall = 0; n_flush = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_mode = n_mode; m_d = n_d;
      m_cyc = n_cyc; m_stall = n_stall; m_flush = n_flush;
    end
  end

  always @(negedge clk) begin
    bit lu;
    int e_pc, e_ifwe, e_iff, e_idb, e_exf;
    lu = id_valid && ex_memread && ex_rd != 0 &&
         (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    n_mode = m_mode; n_d = m_d;
    n_cyc = m_cyc; n_stall = m_stall; n_flush = m_flush;
    e_pc = 0; e_ifwe = 0; e_iff = 0; e_idb = 0; e_exf = 0;
    if (m_mode == 0 || m_mode == 3) begin
      e_iff = 1; e_idb = 1; e_exf = 1;
      if (start) n_mode = 1;
    end else if (m_mode == 1) begin
      n_cyc = sat_inc(m_cyc);
      if (mem_br_taken) begin
        e_pc = 1; e_ifwe = 1; e_iff = 1; e_idb = 1; e_exf = 1;
        n_flush = sat_inc(m_flush);
        if (halt_req) begin n_mode = 2; n_d = 0; end
      end else if (halt_req) begin
        e_ifwe = 1; e_iff = 1;
        n_mode = 2; n_d = 0;
      end else if (lu) begin
        e_idb = 1;
        n_stall = sat_inc(m_stall);
      end else begin
        e_pc = 1; e_ifwe = 1;
      end
    end else begin
      n_cyc = sat_inc(m_cyc);
      e_ifwe = 1; e_iff = 1;
      if (mem_br_taken) begin
        e_pc = 1; e_idb = 1; e_exf = 1;
        n_flush = sat_inc(m_flush);
      end
      n_d = m_d + 1;
      if (n_d == DC) n_mode = 3;
    end
    if (clr_cnt) begin n_cyc = 0; n_stall = 0; n_flush = 0; end
    if (!rst_n) begin
      n_mode = 0; n_d = 0; n_cyc = 0; n_stall = 0; n_flush = 0;
    end
    chk("m_state", int'(state), m_mode);
    chk("m_pc_we", int'(pc_we), e_pc);
    chk("m_ifid_we", int'(ifid_we), e_ifwe);
    chk("m_ifid_flush", int'(ifid_flush), e_iff);
    chk("m_idex_bubble", int'(idex_bubble), e_idb);
    chk("m_exmem_flush", int'(exmem_flush), e_exf);
    chk("m_cycle_cnt", int'(cycle_cnt), m_cyc);
    chk("m_stall_cnt", int'(stall_cnt), m_stall);
    chk("m_flush_cnt", int'(flush_cnt), m_flush);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    halt_req = 0; mem_br_taken = 0; id_valid = 0; ex_memread = 0;
    id_uses_rt = 0; id_rs = 0; id_rt = 0; ex_rd = 0; clr_cnt = 0;
    start = 0;
  endtask

  initial begin
    rst_n = 0; s_rst_n = 0; s_start = 0; s_clr = 0;
    clr_in();
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_pc_we", int'(pc_we), 0);
    chk("rst_ifid_flush", int'(ifid_flush), 1);
    tick();
    rst_n = 1; s_rst_n = 1;
    tick();
    // start -> RUN
    start = 1; #1;
    chk("idle_state", int'(state), 0);
    tick(); start = 0;
    chk("run_state", int'(state), 1);
    chk("run_pc_we", int'(pc_we), 1);
    chk("run_ifid_we", int'(ifid_we), 1);
    tick();
    chk("cyc_after1", int'(cycle_cnt), 1);
    repeat (2) tick();
    // load-use on rs
    id_valid = 1; ex_memread = 1; ex_rd = 5; id_rs = 5; #1;
    chk("lu_pc_we", int'(pc_we), 0);
    chk("lu_ifid_we", int'(ifid_we), 0);
    chk("lu_bubble", int'(idex_bubble), 1);
    tick(); clr_in();
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    chk("lu_state", int'(state), 1);
    // ex_rd = 0: no hazard
    id_valid = 1; ex_memread = 1; ex_rd = 0; id_rs = 0; #1;
    chk("r0_pc_we", int'(pc_we), 1);
    tick(); clr_in();
    chk("r0_stall_cnt", int'(stall_cnt), 1);
    // rt hazard, then same without uses_rt
    id_valid = 1; ex_memread = 1; ex_rd = 7; id_rs = 3; id_rt = 7;
    id_uses_rt = 1;
    tick();
    id_uses_rt = 0;
    tick(); clr_in();
    chk("rt_stall_cnt", int'(stall_cnt), 2);
    // branch beats load-use
    id_valid = 1; ex_memread = 1; ex_rd = 5; id_rs = 5;
    mem_br_taken = 1; #1;
    chk("br_pc_we", int'(pc_we), 1);
    chk("br_ifid_flush", int'(ifid_flush), 1);
    chk("br_bubble", int'(idex_bubble), 1);
    chk("br_exmem_flush", int'(exmem_flush), 1);
    tick(); clr_in();
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 2);
    // halt with branch in 2nd DRAIN cycle
    halt_req = 1; tick(); halt_req = 0;
    chk("dr1_state", int'(state), 2);
    chk("dr1_pc_we", int'(pc_we), 0);
    tick();
    mem_br_taken = 1; #1;
    chk("dr2_pc_we", int'(pc_we), 1);
    tick(); mem_br_taken = 0;
    chk("dr3_state", int'(state), 2);
    tick();
    chk("dr4_state", int'(state), 2);
    tick();
    chk("halt_state", int'(state), 3);
    start = 1; tick(); start = 0;
    chk("resume_state", int'(state), 1);
    // branch + halt together
    mem_br_taken = 1; halt_req = 1; #1;
    chk("bh_pc_we", int'(pc_we), 1);
    tick(); clr_in();
    chk("bh_state", int'(state), 2);
    repeat (3) tick();
    chk("bh_last_drain", int'(state), 2);
    tick();
    chk("bh_halt", int'(state), 3);
    start = 1; tick(); start = 0;
    // clear with increment pending
    tick();
    clr_cnt = 1; tick(); clr_cnt = 0;
    chk("clr_cyc", int'(cycle_cnt), 0);
    chk("clr_flush", int'(flush_cnt), 0);
    tick();
    chk("post_clr_cyc", int'(cycle_cnt), 1);
    // async reset in 2nd DRAIN cycle
    halt_req = 1; tick(); halt_req = 0;
    tick();
    #2 rst_n = 0; #1;
    chk("arst_state", int'(state), 0);
    chk("arst_cyc", int'(cycle_cnt), 0);
    chk("arst_stall", int'(stall_cnt), 0);
    tick(); tick();
    rst_n = 1;
    repeat (3) tick();
    chk("wait_idle", int'(state), 0);
    start = 1; tick(); start = 0;
    chk("restart", int'(state), 1);
    // saturation on 3-bit instance
    s_start = 1; tick(); s_start = 0;
    repeat (10) tick();
    chk("sat_hold", int'(s_cyc), 7);
    s_clr = 1; tick(); s_clr = 0;
    chk("sat_clr", int'(s_cyc), 0);
    tick();
    chk("sat_after", int'(s_cyc), 1);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
